raster_to_block: RTL

- Converts a raster-scan 8-bit grayscale pixel stream into 8x8 block order (block-row-major, row-major within each block).
- Sits directly upstream of the adaptive threshold engine, which expects 64 consecutive pixels per block.
- Holds two 8-line banks (ping-pong): one fills from the raster input while the other drains block by block.
- Valid/ready handshake on both sides; one pixel per cycle sustained.

---
 rtl/raster_to_block.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/raster_to_block.sv
// Raster-scan to 8x8 block-order reorder buffer with ping-pong line banks.
// Optional R2B_MARKERS_EN adds start-of-block / end-of-frame markers.
module raster_to_block #(
    parameter int IMG_W = 48,
    parameter int IMG_H = 32,
    parameter int BW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    pix_data,
    output logic [BW-1:0] out_blk
`ifdef R2B_MARKERS_EN
    ,
    output logic          out_sob,
    output logic          out_eof
`endif
);

    localparam int BANK  = 8 * IMG_W;
    localparam int AW    = $clog2(BANK);
    localparam int NBC   = IMG_W / 8;
    localparam int NBAND = IMG_H / 8;
    localparam int CW    = (NBC > 1) ? $clog2(NBC) : 1;
    localparam int HB    = (NBAND > 1) ? $clog2(NBAND) : 1;
    localparam logic [AW:0] BOFF = (AW+1)'(BANK);

    logic [7:0]    mem [2*BANK];
    logic [1:0]    full;
    logic          wb, rb, relb;
    logic [AW-1:0] wa;
    logic [CW-1:0] bc;
    logic [2:0]    r, c;
    logic [HB-1:0] band;

    logic          p_v, p_last;
    logic [BW-1:0] p_blk;
    logic [7:0]    rdata;

    logic [7:0]    sk_pix [2];
    logic [BW-1:0] sk_blk [2];
    logic [1:0]    sk_last;
    logic          hd;
    logic [1:0]    cnt;

    logic          wr, wlast, rlast, iss, pop, tail;
    logic [AW:0]   waddr, raddr;
    logic [BW-1:0] blk;

    assign in_ready  = !full[wb];
    assign wr        = in_valid && in_ready;
    assign wlast     = (wa == AW'(BANK-1));
    assign out_valid = (cnt != 2'd0);
    assign pop       = out_valid && out_ready;
    assign tail      = hd ^ cnt[0];
    assign pix_data  = sk_pix[hd];
    assign out_blk   = sk_blk[hd];

    assign rlast = (bc == CW'(NBC-1)) && (r == 3'd7) && (c == 3'd7);
    assign blk   = BW'(band * NBC) + BW'(bc);

    // Issue only when the read slot plus skid can absorb the result.
    assign iss = full[rb] &&
        (({1'b0, cnt} + {2'b0, p_v}) <= ({2'b0, pop} + 3'd1));

    assign waddr = {1'b0, wa} + (wb ? BOFF : '0);
    assign raddr = (AW+1)'(r * IMG_W) + (AW+1)'({bc, 3'b000})
                 + (AW+1)'(c) + (rb ? BOFF : '0);

    always_ff @(posedge clk) begin
        if (wr)
            mem[waddr] <= in_data;
        if (iss)
            rdata <= mem[raddr];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            full      <= '0;
            wb        <= 1'b0;
            rb        <= 1'b0;
            relb      <= 1'b0;
            wa        <= '0;
            bc        <= '0;
            r         <= '0;
            c         <= '0;
            band      <= '0;
            p_v       <= 1'b0;
            p_last    <= 1'b0;
            p_blk     <= '0;
            sk_pix[0] <= '0;
            sk_pix[1] <= '0;
            sk_blk[0] <= '0;
            sk_blk[1] <= '0;
            sk_last   <= '0;
            hd        <= 1'b0;
            cnt       <= '0;
        end else begin
            if (wr) begin
                wa <= wlast ? '0 : wa + 1'b1;
                if (wlast) begin
                    full[wb] <= 1'b1;
                    wb       <= !wb;
                end
            end
            // A bank is released only once its final pixel leaves the skid.
            if (pop && sk_last[hd]) begin
                full[relb] <= 1'b0;
                relb       <= !relb;
            end
            if (iss) begin
                c <= c + 3'd1;
                if (c == 3'd7) begin
                    r <= r + 3'd1;
                    if (r == 3'd7) begin
                        if (bc == CW'(NBC-1)) begin
                            bc   <= '0;
                            rb   <= !rb;
                            band <= (band == HB'(NBAND-1)) ? '0 : band + 1'b1;
                        end else begin
                            bc <= bc + 1'b1;
                        end
                    end
                end
            end
            p_v <= iss;
            if (iss) begin
                p_blk  <= blk;
                p_last <= rlast;
            end
            if (p_v) begin
                sk_pix[tail]  <= rdata;
                sk_blk[tail]  <= p_blk;
                sk_last[tail] <= p_last;
            end
            if (pop)
                hd <= !hd;
            cnt <= cnt + {1'b0, p_v} - {1'b0, pop};
        end
    end

`ifdef R2B_MARKERS_EN
    logic       p_sob, p_eof;
    logic [1:0] sk_sob, sk_eof;

    always_ff @(posedge clk) begin
        if (!reset) begin
            p_sob  <= 1'b0;
            p_eof  <= 1'b0;
            sk_sob <= '0;
            sk_eof <= '0;
        end else begin
            if (iss) begin
                p_sob <= (r == 3'd0) && (c == 3'd0);
                p_eof <= rlast && (band == HB'(NBAND-1));
            end
            if (p_v) begin
                sk_sob[tail] <= p_sob;
                sk_eof[tail] <= p_eof;
            end
        end
    end

    assign out_sob = out_valid && sk_sob[hd];
    assign out_eof = out_valid && sk_eof[hd];
`endif

endmodule
